// File: rtl/modbus_resp_tx.sv
`default_nettype none
// ============================================================================
// Module   : modbus_resp_tx
// Brief    : Modbus RTU slave response framer. Builds the 0x03, 0x06 or
//            exception reply, computes CRC-16 in-block, sends the frame byte by
//            byte over a tx_start/tx_done handshake, then holds the
//            3.5-character inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module modbus_resp_tx #(
  parameter logic [7:0] ADDR      = 8'h01,
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD_RATE = 115200
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tx_req,
  input  logic [7:0]  func_code,
  input  logic [15:0] reg_addr,
  input  logic [15:0] reg_data,
  input  logic        exc_en,
  input  logic [7:0]  exc_code,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done
);

  // 3.5 characters of 11 bits each, rounded up to 39 bit times
  localparam int c_GAP_CYC = (CLK_FREQ / BAUD_RATE) * 39;
  localparam int c_GAP_W   = $clog2(c_GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_buf [8];
  logic [2:0]           r_plen;
  logic [2:0]           r_idx;
  logic [15:0]          r_crc;
  logic [3:0]           r_steps;
  logic [c_GAP_W-1:0]   r_gap_cnt;

  logic                 w_req_ok;
  logic                 w_is_payload;
  logic [2:0]           w_last;
  logic [7:0]           w_cur_byte;

  function automatic logic [15:0] crc_step(input logic [15:0] c);
    crc_step = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  assign w_req_ok     = tx_req && (exc_en || func_code == 8'h03 || func_code == 8'h06);
  assign w_last       = r_plen + 3'd1;
  assign w_is_payload = (r_idx < r_plen);

  // After the payload the two CRC bytes follow, low byte first
  always_comb begin
    w_cur_byte = r_crc[15:8];
    if (w_is_payload)
      w_cur_byte = r_buf[r_idx];
    else if (r_idx == r_plen)
      w_cur_byte = r_crc[7:0];
  end

  always_comb begin
    w_next     = r_state;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_req_ok)
          w_next = S_LOAD;
      end
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        tx_start = 1'b1;
        tx_data  = w_cur_byte;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        tx_data = w_cur_byte;
        if (tx_done) begin
          if (r_idx == w_last) begin
            frame_done = 1'b1;
            w_next     = S_GAP;
          end else begin
            w_next = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_W'(c_GAP_CYC - 1))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_plen    <= 3'd0;
      r_idx     <= 3'd0;
      r_gap_cnt <= '0;
      for (int i = 0; i < 8; i++)
        r_buf[i] <= 8'h00;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req_ok) begin
            r_idx    <= 3'd0;
            r_buf[0] <= ADDR;
            r_buf[6] <= 8'h00;
            r_buf[7] <= 8'h00;
            if (exc_en) begin
              r_plen   <= 3'd3;
              r_buf[1] <= func_code | 8'h80;
              r_buf[2] <= exc_code;
              r_buf[3] <= 8'h00;
              r_buf[4] <= 8'h00;
              r_buf[5] <= 8'h00;
            end else if (func_code == 8'h03) begin
              r_plen   <= 3'd5;
              r_buf[1] <= 8'h03;
              r_buf[2] <= 8'h02;
              r_buf[3] <= reg_data[15:8];
              r_buf[4] <= reg_data[7:0];
              r_buf[5] <= 8'h00;
            end else begin
              r_plen   <= 3'd6;
              r_buf[1] <= 8'h06;
              r_buf[2] <= reg_addr[15:8];
              r_buf[3] <= reg_addr[7:0];
              r_buf[4] <= reg_data[15:8];
              r_buf[5] <= reg_data[7:0];
            end
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            if (r_idx == w_last)
              r_gap_cnt <= '0;
            else
              r_idx <= r_idx + 3'd1;
          end
        end
        S_GAP: r_gap_cnt <= r_gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Bit-serial CRC: the byte is folded in on SEND, then eight shift steps run
  // while the UART is still clocking the byte out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_crc   <= 16'hFFFF;
      r_steps <= 4'd0;
    end else if (r_state == S_IDLE && w_req_ok) begin
      r_crc   <= 16'hFFFF;
      r_steps <= 4'd0;
    end else if (r_state == S_SEND && w_is_payload) begin
      r_crc   <= r_crc ^ {8'h00, r_buf[r_idx]};
      r_steps <= 4'd8;
    end else if (r_steps != 4'd0) begin
      r_crc   <= crc_step(r_crc);
      r_steps <= r_steps - 4'd1;
    end
  end

endmodule
`default_nettype wire
